// File: rtl/mm_stream_reader_pkg.sv
// Shared types and constants for the memory-to-stream reader.
package mm_stream_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 12;

  // Output FIFO depth; also the limit on reads outstanding (queued + in flight).
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/mm_stream_reader_skid_fifo.sv
// Two-entry output FIFO: push port from the buffer read return, valid/ready
// pop port toward the stream, and an occupancy count for read throttling.
module stream_skid_fifo
  import mm_stream_reader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  output logic                  valid,
  output logic [WIDTH-1:0]      data,
  input  logic                  ready,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      head_q;
  logic [WIDTH-1:0]      tail_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  pop;

  assign pop   = valid && ready;
  assign valid = (count_q != '0);
  // Empty FIFO presents zeros so the stream data is clean after reset.
  assign data  = valid ? head_q : '0;
  assign count = count_q;

  // Occupancy tracking; the only state that needs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + FIFO_CNT_W'(1);
    end else if (pop && !push) begin
      count_q <= count_q - FIFO_CNT_W'(1);
    end
  end

  // Entry storage: head is always the oldest word, tail the next one.
  // NOTE: storage has no reset on purpose; count_q alone says which entries hold data.
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      if (count_q == '0) head_q <= push_data;
      else               tail_q <= push_data;
    end else if (pop && !push) begin
      head_q <= tail_q;
    end else if (push && pop) begin
      if (count_q == FIFO_CNT_W'(1)) begin
        head_q <= push_data;
      end else begin
        head_q <= tail_q;
        tail_q <= push_data;
      end
    end
  end

endmodule

// File: rtl/mm_stream_reader.sv
// Memory-to-stream stage: on start, reads words 0..len from a synchronous-read
// buffer and emits them as an AXI4-Stream, with tlast on the final word.
module mm_stream_reader
  import mm_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int OUT_W = FIFO_CNT_W + 1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH-1:0]   beat_cnt;
  logic                    inflight;
  logic                    pop;
  logic                    issue;
  logic                    push_last;
  logic [OUT_W-1:0]        outstanding;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic [DATA_WIDTH:0]     fifo_head;

  assign pop       = m_axis_tvalid && m_axis_tready;
  assign push_last = (beat_cnt == len_q);
  assign mem_en    = issue;
  assign mem_addr  = addr;

  // Read throttle: a slot freed by this cycle's pop can be refilled right away,
  // which keeps one beat per cycle while queued + in-flight stays within depth.
  always_comb begin
    // NOTE: every output of this block is assigned first, so no path can infer a latch.
    outstanding = {1'b0, fifo_count} + {{(OUT_W-1){1'b0}}, inflight}
                - {{(OUT_W-1){1'b0}}, pop};
    issue       = (state == RUN) && (outstanding < OUT_W'(FIFO_DEPTH));
  end

  // Control FSM plus address, beat and in-flight tracking.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      len_q    <= '0;
      addr     <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so later lines in this block
      // override earlier defaults without ordering hazards between registers.
      done     <= 1'b0;
      inflight <= issue;
      if (inflight) beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            addr     <= '0;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            // The last address is not incremented, so the counter never wraps.
            if (addr == len_q) state <= DRAIN;
            else               addr  <= addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (pop && m_axis_tlast) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (inflight),
    .push_data ({push_last, mem_rdata}),
    .valid     (m_axis_tvalid),
    .data      (fifo_head),
    .ready     (m_axis_tready),
    .count     (fifo_count)
  );

  assign m_axis_tdata = fifo_head[DATA_WIDTH-1:0];
  assign m_axis_tlast = fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_mm_stream_reader.sv
// Testbench for mm_stream_reader: random buffer contents and tready patterns,
// checked against an expected stream built directly from the buffer contents.
module tb_mm_stream_reader;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int AWS = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            stamp;
  } beat_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Main instance (default widths)
  logic          areset, start, busy, done, mem_en;
  logic [AW-1:0] len, mem_addr;
  logic [DW-1:0] mem_rdata, m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;

  // Small instance (ADDR_WIDTH=4) for the full-buffer boundary
  logic           start_s, busy_s, done_s, mem_en_s;
  logic [AWS-1:0] len_s, mem_addr_s;
  logic [DW-1:0]  mem_rdata_s, tdata_s;
  logic           tvalid_s, tlast_s;
  logic           tready_s;

  mm_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset), .start(start), .len(len), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  mm_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWS)) dut_s (
    .aclk(aclk), .areset(areset), .start(start_s), .len(len_s), .busy(busy_s), .done(done_s),
    .mem_en(mem_en_s), .mem_addr(mem_addr_s), .mem_rdata(mem_rdata_s),
    .m_axis_tdata(tdata_s), .m_axis_tvalid(tvalid_s),
    .m_axis_tready(tready_s), .m_axis_tlast(tlast_s)
  );

  // Synchronous-read buffer models
  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] mem_s [0:(1<<AWS)-1];
  always @(posedge aclk) if (mem_en)   mem_rdata   <= mem[mem_addr];
  always @(posedge aclk) if (mem_en_s) mem_rdata_s <= mem_s[mem_addr_s];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge aclk) cyc++;

  // Random tready driver, active only while rand_ready is set
  bit rand_ready = 1'b0;
  always @(posedge aclk) begin
    #1;
    if (rand_ready) m_axis_tready = ($urandom_range(0, 1) == 1);
  end

  // Observation queues; a stamp is the clock edge at which the value is sampled
  beat_t beats[$];
  int    issue_addr[$];
  int    issue_stamp[$];
  int    done_stamps[$];
  bit    busy_hist[int];
  int    outstanding = 0;
  bit    prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic  prev_last;

  beat_t beats_s[$];
  int    addr_s[$];
  int    done_cnt_s = 0;

  always @(negedge aclk) begin
    int  st;
    bit  hs;
    beat_t b;
    st = cyc + 1;
    hs = m_axis_tvalid && m_axis_tready;
    busy_hist[st] = busy;
    if (!areset) begin
      if (hs) begin
        b.data = m_axis_tdata; b.last = m_axis_tlast; b.stamp = st;
        beats.push_back(b);
      end
      if (mem_en) begin
        issue_addr.push_back(int'(mem_addr));
        issue_stamp.push_back(st);
      end
      if (done) done_stamps.push_back(st);
    end
    // A stalled beat must be held unchanged until it is accepted
    if (prev_stall) begin
      checks++;
      if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
        errors++;
        $display("FAIL stall_hold @%0d: tvalid=%0b tdata=%h tlast=%0b, required tvalid=1 tdata=%h tlast=%0b",
                 st, m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
      end
    end
    prev_stall = m_axis_tvalid && !m_axis_tready && !areset;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    // Reads issued but not yet emitted never exceed the FIFO depth
    if (areset) outstanding = 0;
    else begin
      outstanding = outstanding + (mem_en ? 1 : 0) - (hs ? 1 : 0);
      checks++;
      if (outstanding > 2) begin
        errors++;
        $display("FAIL outstanding @%0d: got %0d, required <= 2", st, outstanding);
      end
    end
  end

  always @(negedge aclk) begin
    beat_t b;
    if (!areset) begin
      if (tvalid_s && tready_s) begin
        b.data = tdata_s; b.last = tlast_s; b.stamp = cyc + 1;
        beats_s.push_back(b);
      end
      if (mem_en_s) addr_s.push_back(int'(mem_addr_s));
      if (done_s) done_cnt_s++;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_mon();
    beats.delete(); issue_addr.delete(); issue_stamp.delete(); done_stamps.delete();
  endtask

  task automatic fill_mem(input int n);
    for (int i = 0; i < n; i++) mem[i] = $urandom;
  endtask

  task automatic pulse_start(input int l, output int t);
    start = 1'b1;
    len   = AW'(l);
    t     = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (done_stamps.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (done_stamps.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: done count %0d after %0d cycles, required %0d", name, done_stamps.size(), budget, n);
    end
    repeat (3) tick();
  endtask

  // Reference: words mem[0..l] in order, tlast only on index l, addresses 0..l, one done
  task automatic check_stream(input string name, input int l);
    int n;
    bit bad;
    checks++;
    if (beats.size() != l + 1) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d, required %0d", name, beats.size(), l + 1);
    end
    n = (beats.size() < l + 1) ? beats.size() : l + 1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (beats[i].data !== mem[i] || beats[i].last !== logic'(i == l)) begin
        errors++;
        $display("FAIL %s_beat%0d: got data=%h last=%0b, required data=%h last=%0b",
                 name, i, beats[i].data, beats[i].last, mem[i], (i == l));
      end
    end
    bad = (issue_addr.size() != l + 1);
    for (int i = 0; i < issue_addr.size() && !bad; i++) if (issue_addr[i] != i) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_addresses: got %0d reads, required %0d reads at 0..%0d", name, issue_addr.size(), l + 1, l);
    end
    checks++;
    if (done_stamps.size() != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, required 1", name, done_stamps.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    checks++;
    if ({busy, done, mem_en, m_axis_tvalid, m_axis_tlast} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: busy/done/mem_en/tvalid/tlast=%b, required 00000",
               {busy, done, mem_en, m_axis_tvalid, m_axis_tlast});
    end
    checks++;
    if (m_axis_tdata !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: tdata=%h mem_addr=%h, required 0 and 0", m_axis_tdata, mem_addr);
    end
  endtask

  task automatic test_basic();
    int t;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
    m_axis_tready = 1'b1;
    clear_mon();
    pulse_start(3, t);
    wait_done("basic", 1, 50);
    check_stream("basic", 3);
    for (int i = 0; i < 4 && i < issue_stamp.size(); i++) begin
      checks++;
      if (issue_stamp[i] != t + 1 + i) begin
        errors++;
        $display("FAIL basic_read%0d_cycle: got T+%0d, required T+%0d", i, issue_stamp[i] - t, 1 + i);
      end
    end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].stamp != t + 3 + i) begin
        errors++;
        $display("FAIL basic_beat%0d_cycle: got T+%0d, required T+%0d", i, beats[i].stamp - t, 3 + i);
      end
    end
    if (done_stamps.size() > 0) begin
      checks++;
      if (done_stamps[0] != t + 7) begin
        errors++;
        $display("FAIL basic_done_cycle: got T+%0d, required T+7", done_stamps[0] - t);
      end
    end
    for (int k = 0; k <= 7; k++) begin
      checks++;
      if (busy_hist[t + k] != (k >= 1 && k <= 6)) begin
        errors++;
        $display("FAIL basic_busy_T+%0d: got %0b, required %0b", k, busy_hist[t + k], (k >= 1 && k <= 6));
      end
    end
  endtask

  task automatic test_single();
    int t;
    fill_mem(1);
    m_axis_tready = 1'b1;
    clear_mon();
    pulse_start(0, t);
    wait_done("single", 1, 30);
    check_stream("single", 0);
    if (beats.size() > 0 && done_stamps.size() > 0) begin
      checks++;
      if (beats[0].stamp != t + 3 || done_stamps[0] != beats[0].stamp + 1) begin
        errors++;
        $display("FAIL single_timing: beat T+%0d done T+%0d, required beat T+3 done T+4",
                 beats[0].stamp - t, done_stamps[0] - t);
      end
    end
  endtask

  task automatic test_random_ready();
    int t, l;
    for (int it = 0; it < 3; it++) begin
      l = (it == 0) ? 7 : $urandom_range(1, 40);
      fill_mem(l + 1);
      clear_mon();
      rand_ready = 1'b1;
      pulse_start(l, t);
      wait_done("rand_ready", 1, 40 * (l + 1) + 100);
      rand_ready = 1'b0;
      m_axis_tready = 1'b1;
      check_stream("rand_ready", l);
    end
  endtask

  task automatic test_stalled();
    int t;
    // tready low throughout: reads must stop at two outstanding, then resume losslessly
    fill_mem(6);
    clear_mon();
    m_axis_tready = 1'b0;
    pulse_start(5, t);
    repeat (12) tick();
    checks++;
    if (issue_addr.size() != 2 || beats.size() != 0) begin
      errors++;
      $display("FAIL stalled_reads: got %0d reads %0d beats, required 2 reads 0 beats", issue_addr.size(), beats.size());
    end
    m_axis_tready = 1'b1;
    wait_done("stalled", 1, 60);
    check_stream("stalled", 5);
  endtask

  task automatic test_full_buffer();
    int k;
    bit bad;
    for (int i = 0; i < 16; i++) mem_s[i] = $urandom;
    beats_s.delete(); addr_s.delete(); done_cnt_s = 0;
    start_s = 1'b1; len_s = 4'd15;
    tick();
    start_s = 1'b0;
    k = 0;
    while (done_cnt_s == 0 && k < 100) begin tick(); k++; end
    repeat (5) tick();
    checks++;
    if (done_cnt_s != 1 || beats_s.size() != 16) begin
      errors++;
      $display("FAIL full_buffer_count: got %0d done %0d beats, required 1 done 16 beats", done_cnt_s, beats_s.size());
    end
    bad = (addr_s.size() != 16);
    for (int i = 0; i < addr_s.size() && !bad; i++) if (addr_s[i] != i) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL full_buffer_addr: got %0d reads, required 16 reads at 0..15 with no wrap", addr_s.size());
    end
    for (int i = 0; i < 16 && i < beats_s.size(); i++) begin
      checks++;
      if (beats_s[i].data !== mem_s[i] || beats_s[i].last !== logic'(i == 15)) begin
        errors++;
        $display("FAIL full_buffer_beat%0d: got data=%h last=%0b, required data=%h last=%0b",
                 i, beats_s[i].data, beats_s[i].last, mem_s[i], (i == 15));
      end
    end
  endtask

  task automatic test_start_ignored();
    int t;
    fill_mem(4);
    m_axis_tready = 1'b1;
    clear_mon();
    pulse_start(3, t);                  // now just after edge T
    tick();                             // after T+1
    start = 1'b1; tick(); start = 1'b0; // sampled at T+2
    tick();                             // after T+3
    start = 1'b1; tick(); start = 1'b0; // sampled at T+4
    tick(); tick();                     // after T+6
    start = 1'b1; len = AW'(3);
    tick();                             // sampled at T+7, the done cycle
    start = 1'b0;
    wait_done("back_to_back", 2, 40);
    checks++;
    if (done_stamps.size() != 2 || beats.size() != 8) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d done %0d beats, required 2 done 8 beats", done_stamps.size(), beats.size());
    end
    if (done_stamps.size() == 2) begin
      checks++;
      if (done_stamps[0] != t + 7 || done_stamps[1] != t + 14) begin
        errors++;
        $display("FAIL back_to_back_done_cycles: got T+%0d,T+%0d, required T+7,T+14",
                 done_stamps[0] - t, done_stamps[1] - t);
      end
    end
    for (int i = 0; i < 8 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].data !== mem[i % 4] || beats[i].last !== logic'(i % 4 == 3)) begin
        errors++;
        $display("FAIL back_to_back_beat%0d: got data=%h last=%0b, required data=%h last=%0b",
                 i, beats[i].data, beats[i].last, mem[i % 4], (i % 4 == 3));
      end
    end
  endtask

  task automatic test_abort();
    int t;
    fill_mem(8);
    m_axis_tready = 1'b1;
    clear_mon();
    pulse_start(7, t);                  // after edge T
    repeat (3) tick();                  // after T+3
    areset = 1'b1;
    tick();                             // reset sampled at T+4
    areset = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: tvalid=%0b busy=%0b mem_en=%0b done=%0b, required all 0",
               m_axis_tvalid, busy, mem_en, done);
    end
    repeat (10) tick();
    checks++;
    if (done_stamps.size() != 0 || issue_addr.size() != 3) begin
      errors++;
      $display("FAIL abort_quiet: got %0d done %0d reads, required 0 done 3 reads", done_stamps.size(), issue_addr.size());
    end
    clear_mon();
    pulse_start(7, t);
    wait_done("abort_restart", 1, 60);
    check_stream("abort_restart", 7);
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; len = '0; m_axis_tready = 1'b1;
    start_s = 1'b0; len_s = '0; tready_s = 1'b1;
    test_reset();
    test_basic();
    test_single();
    test_random_ready();
    test_stalled();
    test_full_buffer();
    test_start_ignored();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
